stoch_maxpool_sched: RTL and testbench

//  Time-multiplexes one stochastic signed maxpool datapath (nmax array, CHANNELS = one group) over NUM_GROUPS

---
 rtl/stoch_pkg.sv | 15 +
 rtl/stoch_beat_counter.sv | 28 ++
 rtl/stoch_maxpool_sched.sv | 125 ++++++++++++
 tb/tb_stoch_maxpool_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/stoch_pkg.sv
// Shared types and elaboration helpers for the stochastic maxpool scheduler.
package stoch_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, WARM, RUN, FLUSH, DONE} sched_state_t;

  // Width needed to index v items; never below one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stoch_beat_counter.sv
// Beat counter: synchronous load-to-zero, increment on accepted beat, and a
// terminal-count flag that fires on the beat that brings the count to limit.
module stoch_beat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_p1;

  // One extra bit so the compare can never alias on a wrapped count.
  assign cnt_p1 = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign hit    = inc & (cnt_p1 == {1'b0, limit});

  // Count register: clear has priority over increment.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (inc)  cnt <= cnt_p1[CNT_W-1:0];
  end

endmodule

// File: rtl/stoch_maxpool_sched.sv
// Scheduler that time-multiplexes one stochastic maxpool datapath over
// NUM_GROUPS channel groups: clear, warm-up, accumulate, report, next group.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one cycle: clear nmax state and counter bank
// WARM  | consume WARMUP settling beats, nothing accumulated
// RUN   | consume STREAM_LEN beats into the counter bank
// FLUSH | one cycle: counter bank holds result for group_sel
// DONE  | one cycle: end-of-pass pulse
module stoch_maxpool_sched
  import stoch_pkg::*;
#(
  parameter  int NUM_GROUPS = 4,
  parameter  int STREAM_LEN = 256,
  parameter  int WARMUP     = 8,
  localparam int GRP_W      = clog2_min1(NUM_GROUPS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [GRP_W-1:0] group_sel,
  output logic             pool_clr,
  output logic             pool_en,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             grp_done,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = clog2_min1(max2(STREAM_LEN, WARMUP) + 1);
  localparam logic [CNT_W-1:0] WARM_LIM = CNT_W'(WARMUP);
  localparam logic [CNT_W-1:0] RUN_LIM  = CNT_W'(STREAM_LEN);
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);
  localparam bit               HAS_WARM = (WARMUP > 0);

  sched_state_t     state, state_nxt;
  logic [GRP_W-1:0] grp_q;
  logic             abort_clr_q;
  logic             abort_act;
  logic             beat;
  logic             cnt_clr;
  logic             cnt_hit;
  logic [CNT_W-1:0] cnt_lim;

  // abort is meaningless in IDLE, so a start arriving with it still launches.
  assign abort_act = abort & (state != IDLE);
  assign beat      = bit_valid & bit_ready;
  assign cnt_lim   = (state == WARM) ? WARM_LIM : RUN_LIM;
  assign cnt_clr   = (state == CLEAR) | ((state == WARM) & cnt_hit) | abort_act;

  stoch_beat_counter #(.CNT_W(CNT_W)) u_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr   (cnt_clr),
    .inc   (beat),
    .limit (cnt_lim),
    .hit   (cnt_hit)
  );

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = HAS_WARM ? WARM : RUN;
      WARM:    if (cnt_hit) state_nxt = RUN;
      RUN:     if (cnt_hit) state_nxt = FLUSH;
      FLUSH:   state_nxt = (grp_q == LAST_GRP) ? DONE : CLEAR;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_act) state_nxt = IDLE;
  end

  // Group index and the one-shot nmax clear that follows an abort.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grp_q       <= '0;
      abort_clr_q <= 1'b0;
    end else begin
      abort_clr_q <= abort_act;
      if (abort_act)                              grp_q <= '0;
      else if ((state == IDLE) && start)          grp_q <= '0;
      else if ((state == FLUSH) && (grp_q != LAST_GRP)) grp_q <= grp_q + GRP_W'(1);
      else if (state == DONE)                     grp_q <= '0;
    end
  end

  // Moore outputs plus the abort-gated pulses.
  always_comb begin
    bit_ready = 1'b0;
    pool_clr  = abort_clr_q;
    acc_clr   = 1'b0;
    grp_done  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      CLEAR: begin
        pool_clr = 1'b1;
        acc_clr  = 1'b1;
      end
      WARM, RUN: bit_ready = 1'b1;
      FLUSH:     grp_done  = ~abort;
      DONE:      done      = ~abort;
      default:   ;
    endcase
  end

  // A beat taken in the abort cycle still advances nmax but is not counted.
  assign pool_en   = beat;
  assign acc_en    = beat & (state == RUN) & ~abort;
  assign group_sel = grp_q;

endmodule

// File: tb/tb_stoch_maxpool_sched.sv
// Directed bench for stoch_maxpool_sched with a per-group scoreboard.
module tb_stoch_maxpool_sched;

  localparam int G     = 2;
  localparam int S     = 4;
  localparam int W     = 2;
  localparam int GRP_W = 1;
  localparam int LAT   = G * (W + S + 2) + 1;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic start = 1'b0, abort = 1'b0, bit_valid = 1'b0;
  logic bit_ready, pool_clr, pool_en, acc_clr, acc_en, grp_done, busy, done;
  logic [GRP_W-1:0] group_sel;

  logic start_w0 = 1'b0, abort_w0 = 1'b0, bv_w0 = 1'b0;
  logic bit_ready_w0, pool_clr_w0, pool_en_w0, acc_clr_w0, acc_en_w0;
  logic grp_done_w0, busy_w0, done_w0;
  logic [GRP_W-1:0] group_sel_w0;

  int errors = 0;
  int checks = 0;

  typedef struct { int grp; int acc; int pool; } grp_exp_t;
  grp_exp_t sb[$];
  grp_exp_t mon_e;
  int acc_cnt = 0, pool_cnt = 0, clr_seen = 0, done_seen = 0;

  always #5 CLK = ~CLK;

  stoch_maxpool_sched #(.NUM_GROUPS(G), .STREAM_LEN(S), .WARMUP(W)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .abort(abort), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .group_sel(group_sel), .pool_clr(pool_clr), .pool_en(pool_en),
    .acc_clr(acc_clr), .acc_en(acc_en), .grp_done(grp_done), .busy(busy), .done(done)
  );

  stoch_maxpool_sched #(.NUM_GROUPS(G), .STREAM_LEN(S), .WARMUP(0)) dut_w0 (
    .CLK(CLK), .nRST(nRST), .start(start_w0), .abort(abort_w0), .bit_valid(bv_w0),
    .bit_ready(bit_ready_w0), .group_sel(group_sel_w0), .pool_clr(pool_clr_w0),
    .pool_en(pool_en_w0), .acc_clr(acc_clr_w0), .acc_en(acc_en_w0),
    .grp_done(grp_done_w0), .busy(busy_w0), .done(done_w0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_pass();
    for (int g = 0; g < G; g++) sb.push_back('{grp: g, acc: S, pool: W + S});
  endtask

  // Called #1 into an IDLE cycle; returns #1 into cycle 1 (CLEAR).
  task automatic launch(input bit hold);
    start = 1'b1;
    @(posedge CLK); #1;
    if (!hold) start = 1'b0;
  endtask

  // mode 0: bit_valid always 1; mode 1: bit_valid = cycle index bit 0.
  task automatic wait_done(input int mode, input int n0, output int lat);
    lat = 0;
    for (int n = n0; n <= n0 + 400; n++) begin
      bit_valid = (mode == 0) ? 1'b1 : n[0];
      @(negedge CLK);
      if (done) begin
        lat = n;
        break;
      end
      @(posedge CLK); #1;
    end
    bit_valid = 1'b0;
    @(posedge CLK); #1;
  endtask

  // Monitor: handshake invariants every cycle, scoreboard pop on grp_done.
  always @(negedge CLK) begin
    if (nRST) begin
      if (pool_clr) begin
        acc_cnt  = 0;
        pool_cnt = 0;
        clr_seen++;
      end
      if (pool_en) pool_cnt++;
      if (acc_en)  acc_cnt++;
      chk("pool_en_handshake", 32'(pool_en), 32'(bit_valid & bit_ready));
      chk("acc_en_without_valid", 32'(acc_en & ~bit_valid), 32'd0);
      if (grp_done) begin
        chk("sb_nonempty_at_grp_done", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("grp_done_group", 32'(group_sel), 32'(mon_e.grp));
          chk("grp_acc_beats", 32'(acc_cnt), 32'(mon_e.acc));
          chk("grp_pool_beats", 32'(pool_cnt), 32'(mon_e.pool));
        end
      end
      if (done) done_seen++;
    end
  end

  initial begin
    int lat, c0, d0, acc_w0;

    // Reset state
    #12;
    chk("reset_outputs", 32'({bit_ready, pool_clr, pool_en, acc_clr, acc_en,
                              grp_done, busy, done, group_sel}), 32'd0);
    chk("reset_outputs_w0", 32'({bit_ready_w0, pool_clr_w0, pool_en_w0, acc_clr_w0, acc_en_w0,
                                 grp_done_w0, busy_w0, done_w0, group_sel_w0}), 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;

    // 1: full pass, no stalls
    c0 = clr_seen;
    push_pass();
    launch(1'b0);
    wait_done(0, 1, lat);
    chk("t1_latency", 32'(lat), 32'(LAT));
    chk("t1_pool_clr_cycles", 32'(clr_seen - c0), 32'(G));
    chk("t1_sb_drained", 32'(sb.size()), 32'd0);

    // 2: alternating bit_valid; every WARM/RUN beat is preceded by one stall
    push_pass();
    launch(1'b0);
    wait_done(1, 1, lat);
    chk("t2_latency_stalled", 32'(lat), 32'(LAT + G * (W + S)));
    chk("t2_sb_drained", 32'(sb.size()), 32'd0);

    // 3: abort on 3rd RUN beat of group 1 (cycle 14)
    d0 = done_seen;
    sb.push_back('{grp: 0, acc: S, pool: W + S});
    launch(1'b0);
    for (int n = 1; n <= 14; n++) begin
      bit_valid = 1'b1;
      abort = (n == 14);
      @(negedge CLK);
      if (n == 14) begin
        chk("t3_abort_cycle_group", 32'(group_sel), 32'd1);
        chk("t3_abort_cycle_pool_en", 32'(pool_en), 32'd1);
        chk("t3_abort_cycle_acc_en", 32'(acc_en), 32'd0);
      end
      @(posedge CLK); #1;
    end
    abort = 1'b0;
    bit_valid = 1'b0;
    @(negedge CLK);
    chk("t3_post_pool_clr", 32'(pool_clr), 32'd1);
    chk("t3_post_group_sel", 32'(group_sel), 32'd0);
    chk("t3_post_busy", 32'(busy), 32'd0);
    chk("t3_post_done_pulses", 32'({grp_done, done}), 32'd0);
    repeat (10) @(posedge CLK);
    #1;
    chk("t3_no_done", 32'(done_seen - d0), 32'd0);
    chk("t3_sb_drained", 32'(sb.size()), 32'd0);

    // 4: start held high across the pass
    push_pass();
    push_pass();
    launch(1'b1);
    wait_done(0, 1, lat);
    chk("t4_first_latency", 32'(lat), 32'(LAT));
    @(negedge CLK);
    chk("t4_idle_gap_busy", 32'(busy), 32'd0);
    chk("t4_idle_gap_clr", 32'(pool_clr), 32'd0);
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    chk("t4_second_clear", 32'({busy, pool_clr, acc_clr}), 32'd7);
    @(posedge CLK); #1;
    wait_done(0, 2, lat);
    chk("t4_second_latency", 32'(lat), 32'(LAT));
    chk("t4_sb_drained", 32'(sb.size()), 32'd0);

    // 5: WARMUP=0 instance goes CLEAR -> RUN
    start_w0 = 1'b1;
    bv_w0 = 1'b1;
    @(posedge CLK); #1;
    start_w0 = 1'b0;
    @(negedge CLK);
    chk("t5_clear", 32'({pool_clr_w0, acc_en_w0}), 32'd2);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("t5_first_beat_acc", 32'({pool_en_w0, acc_en_w0}), 32'd3);
    acc_w0 = acc_en_w0 ? 1 : 0;
    lat = 0;
    for (int n = 3; n <= 200; n++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      if (acc_en_w0) acc_w0++;
      if (done_w0) begin
        lat = n;
        break;
      end
    end
    bv_w0 = 1'b0;
    chk("t5_latency", 32'(lat), 32'(G * (S + 2) + 1));
    chk("t5_acc_beats", 32'(acc_w0), 32'(G * S));
    @(posedge CLK); #1;

    // 6: async reset mid-WARM, then a clean pass launched with abort also high
    push_pass();
    launch(1'b0);
    bit_valid = 1'b1;
    @(posedge CLK); #1;
    #2 nRST = 1'b0;
    #1;
    chk("t6_async_reset_outputs", 32'({bit_ready, pool_clr, pool_en, acc_clr, acc_en,
                                       grp_done, busy, done, group_sel}), 32'd0);
    sb.delete();
    bit_valid = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    push_pass();
    abort = 1'b1;
    launch(1'b0);
    abort = 1'b0;
    wait_done(0, 1, lat);
    chk("t6_clean_latency", 32'(lat), 32'(LAT));
    chk("t6_sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
